// File: rtl/uart_rx_os16.sv
// uart_rx_os16 -- UART receiver with 16x oversampling and 3-sample majority voting.
// Default build receives 8N1 frames (LSB first, idle-high line).
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err.
// Sample k of a bit is the tick that advances scnt to k. The bit value is
// the majority of samples 7, 8 and 9, resolved on the sample-9 tick.

module uart_rx_os16 #(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int DCW     = $clog2(DIV);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;
`endif

    state_e state_q, state_d;

    // input synchronizer and its post-reset fill tracker
    logic       rx_s1_q, rx_s1_d;
    logic       rx_s2_q, rx_s2_d;
    logic [1:0] sync_vld_q, sync_vld_d;
    logic       armed_q, armed_d;

    // oversampling timebase
    logic [DCW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]     scnt_q, scnt_d;
    logic [3:0]     scnt_nxt;
    logic           tick;
    logic           s9;
    logic           wrap;

    // sample capture and frame assembly
    logic       smp7_q, smp7_d;
    logic       smp8_q, smp8_d;
    logic       maj;
    logic       start_det;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bcnt_q, bcnt_d;

    // registered outputs
    logic [7:0] data_q, data_d;
    logic       data_valid_q, data_valid_d;
    logic       frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic       par_bad_q, par_bad_d;
    logic       parity_err_q, parity_err_d;
`endif

    // Front end: synchronizer shift, timebase decode, majority vote, start detection.
    // The start detector is armed only after the synchronizer has carried a real
    // high level since reset, so a line already low when reset releases (a frame
    // in progress) is not mistaken for a start edge.
    always_comb begin
        rx_s1_d    = rx;
        rx_s2_d    = rx_s1_q;
        sync_vld_d = {sync_vld_q[0], 1'b1};
        armed_d    = armed_q | (sync_vld_q[1] & rx_s2_q);
        tick       = (div_cnt_q == DIV_LAST);
        scnt_nxt   = scnt_q + 4'd1;
        s9         = tick && (scnt_nxt == 4'd9);
        wrap       = tick && (scnt_q == 4'd15);
        maj        = (smp7_q & smp8_q) | (smp7_q & rx_s2_q) | (smp8_q & rx_s2_q);
        start_det  = (state_q == S_IDLE) && armed_q && !rx_s2_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; stop handling returns to IDLE mid-stop to catch back-to-back frames.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_det) state_d = S_START;
            end
            S_START: begin
                if (s9 && maj) state_d = S_IDLE;
                else if (wrap) state_d = S_DATA;
            end
            S_DATA: begin
                if (wrap && (bcnt_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (wrap) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (s9) state_d = maj ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (rx_s2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath logic: counters, sample capture, shifting, strobes.
    always_comb begin
        div_cnt_d    = tick ? '0 : div_cnt_q + DCW'(1);
        scnt_d       = tick ? scnt_nxt : scnt_q;
        smp7_d       = (tick && scnt_nxt == 4'd7) ? rx_s2_q : smp7_q;
        smp8_d       = (tick && scnt_nxt == 4'd8) ? rx_s2_q : smp8_q;
        shreg_d      = shreg_q;
        bcnt_d       = bcnt_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        // realign the bit phase to the detected falling edge
        if (start_det) begin
            div_cnt_d = '0;
            scnt_d    = 4'd0;
            bcnt_d    = 3'd0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
        end
        case (state_q)
            S_DATA: begin
                if (s9)   shreg_d = {maj, shreg_q[7:1]};
                if (wrap) bcnt_d  = bcnt_q + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                // even parity: received bit must equal the XOR of the data bits
                if (s9) par_bad_d = maj ^ (^shreg_q);
            end
`endif
            S_STOP: begin
                if (s9) begin
                    if (maj) begin
                        data_d       = shreg_q;
                        data_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = par_bad_q;
`endif
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; synchronizer flops idle high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            sync_vld_q   <= 2'b00;
            armed_q      <= 1'b0;
            div_cnt_q    <= '0;
            scnt_q       <= 4'd0;
            smp7_q       <= 1'b1;
            smp8_q       <= 1'b1;
            shreg_q      <= 8'h00;
            bcnt_q       <= 3'd0;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_s1_q      <= rx_s1_d;
            rx_s2_q      <= rx_s2_d;
            sync_vld_q   <= sync_vld_d;
            armed_q      <= armed_d;
            div_cnt_q    <= div_cnt_d;
            scnt_q       <= scnt_d;
            smp7_q       <= smp7_d;
            smp8_q       <= smp8_d;
            shreg_q      <= shreg_d;
            bcnt_q       <= bcnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
